// File: rtl/mem_access_unit.sv
// Load/store alignment and sub-word unit between the CPU datapath and a word-only data memory.
// Optional macro MISALIGN_TRAP_EN: flag and suppress misaligned accesses instead of truncating the address.
module mem_access_unit #(
    parameter int unsigned RAM_SIZE = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_range_err,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WIDX_W  = 30;
    localparam logic [WIDX_W-1:0] RAM_WORDS = WIDX_W'(RAM_SIZE);

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_RMW_WR = 1'b1
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_nxt;

    op_e                 w_op;
    logic                w_misalign;
    logic                w_range;
    logic [DATA_W-1:0]   w_word_addr;
    logic [15:0]         w_half;
    logic [7:0]          w_byte;
    logic [DATA_W-1:0]   w_merge_half;
    logic [DATA_W-1:0]   w_merge_byte;

    assign w_op        = op_e'(i_op);
    assign w_word_addr = {i_addr[31:2], 2'b00};
    assign w_range     = (i_addr[31:2] >= RAM_WORDS);

    // Alignment check; without the trap, low address bits are simply truncated.
`ifdef MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        case (w_op)
            OP_LW, OP_SW:          w_misalign = (i_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  w_misalign = i_addr[0];
            default:               w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Lane extraction from the memory word (little-endian lanes).
    always_comb begin
        w_half = i_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        w_byte = i_mem_rdata[7:0];
        case (i_addr[1:0])
            2'b00:   w_byte = i_mem_rdata[7:0];
            2'b01:   w_byte = i_mem_rdata[15:8];
            2'b10:   w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
    end

    // Merged word for sub-word stores: current memory word with one lane replaced.
    always_comb begin
        w_merge_half = i_addr[1] ? {i_wdata[15:0], i_mem_rdata[15:0]}
                                 : {i_mem_rdata[31:16], i_wdata[15:0]};
        w_merge_byte = i_mem_rdata;
        case (i_addr[1:0])
            2'b00:   w_merge_byte = {i_mem_rdata[31:8], i_wdata[7:0]};
            2'b01:   w_merge_byte = {i_mem_rdata[31:16], i_wdata[7:0], i_mem_rdata[7:0]};
            2'b10:   w_merge_byte = {i_mem_rdata[31:24], i_wdata[7:0], i_mem_rdata[15:0]};
            default: w_merge_byte = {i_wdata[7:0], i_mem_rdata[23:0]};
        endcase
    end

    // State and latched RMW address/data.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Next-state and combinational outputs; everything is forced low while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        o_rdata     = '0;
        o_stall     = 1'b0;
        o_misalign  = 1'b0;
        o_range_err = 1'b0;
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;

        if (i_reset) begin
            case (r_state)
                S_IDLE: begin
                    o_mem_addr = w_word_addr;
                    if (i_req) begin
                        if (w_misalign || w_range) begin
                            o_misalign  = w_misalign;
                            o_range_err = w_range;
                        end else begin
                            case (w_op)
                                OP_LW: begin
                                    o_mem_rd = 1'b1;
                                    o_rdata  = i_mem_rdata;
                                end
                                OP_LH: begin
                                    o_mem_rd = 1'b1;
                                    o_rdata  = {{16{w_half[15]}}, w_half};
                                end
                                OP_LHU: begin
                                    o_mem_rd = 1'b1;
                                    o_rdata  = {16'h0000, w_half};
                                end
                                OP_LB: begin
                                    o_mem_rd = 1'b1;
                                    o_rdata  = {{24{w_byte[7]}}, w_byte};
                                end
                                OP_LBU: begin
                                    o_mem_rd = 1'b1;
                                    o_rdata  = {24'h000000, w_byte};
                                end
                                OP_SW: begin
                                    o_mem_wr    = 1'b1;
                                    o_mem_wdata = i_wdata;
                                end
                                OP_SH: begin
                                    o_mem_rd    = 1'b1;
                                    o_stall     = 1'b1;
                                    w_addr_nxt  = w_word_addr;
                                    w_wdata_nxt = w_merge_half;
                                    w_state_nxt = S_RMW_WR;
                                end
                                default: begin
                                    o_mem_rd    = 1'b1;
                                    o_stall     = 1'b1;
                                    w_addr_nxt  = w_word_addr;
                                    w_wdata_nxt = w_merge_byte;
                                    w_state_nxt = S_RMW_WR;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    o_mem_wr    = 1'b1;
                    o_mem_addr  = r_addr;
                    o_mem_wdata = r_wdata;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store alignment and sub-word unit between the single-cycle CPU datapath (ALU address, register-file store data) and the word-only data memory.
- Data memory supports only whole-word, word-aligned access with combinational read and posedge write. This block adds byte/halfword loads with sign/zero extension.
- Sub-word stores run as a two-cycle read-modify-write with a CPU stall. Misaligned accesses are detected.
- Byte lanes are little-endian: byte 0 is bits 7:0.

Parameters:
- RAM_SIZE, 16, number of 32-bit words in the attached data memory; word index >= RAM_SIZE raises range_err.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  CPU memory request valid this cycle
- op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- addr  in  32  byte address from ALU
- wdata  in  32  store data from register file; low byte/half used for SB/SH
- rdata  out  32  extended load result to writeback
- stall  out  1  hold PC/pipeline this cycle
- misalign  out  1  access misaligned this cycle
- range_err  out  1  word index addr[31:2] >= RAM_SIZE
- mem_rd  out  1  data-memory read enable
- mem_wr  out  1  data-memory write enable
- mem_addr  out  32  data-memory address, always word-aligned (bits 1:0 = 00)
- mem_wdata  out  32  data-memory write data
- mem_rdata  in  32  data-memory combinational read data

Behaviour:
- FSM has two states: IDLE and RMW_WR. Reset (reset=0) forces IDLE asynchronously and clears the latched address/data registers.
- While reset=0, all outputs are 0; the mem_rd/mem_wr/stall combinational paths are gated.
- Alignment rules:
  - LW/SW need addr[1:0]=00.
  - LH/LHU/SH need addr[0]=0.
  - Byte ops are always aligned.
- A misaligned or out-of-range request in IDLE:
  - mem_rd=mem_wr=0, stall=0, rdata=0.
  - The applicable flag(s) are 1 for that cycle only; no state change.
- In IDLE, all outputs are combinational, with mem_addr = {addr[31:2],2'b00}:
  - Load: mem_rd=1, zero latency, stall=0.
    - LW passes the word through.
    - LH/LHU select half addr[1]; LB/LBU select byte addr[1:0].
    - LH/LB sign-extend; LHU/LBU zero-extend.
  - SW: mem_wr=1, mem_wdata=wdata, stall=0, single cycle.
  - SH/SB (aligned, in range):
    - mem_rd=1, stall=1.
    - The merged word (mem_rdata with the selected lane replaced by wdata[15:0] or wdata[7:0]) and mem_addr are registered at the clock edge; next state is RMW_WR.
  - req=0: all enables 0, stall=0, rdata=0.
- In RMW_WR:
  - mem_wr=1, mem_addr/mem_wdata come from the latched registers, mem_rd=0, stall=0, rdata=0.
  - The CPU's req/op/addr are ignored. The same store instruction is still presented and must not retrigger.
  - Unconditional return to IDLE next edge.
- A sub-word store therefore takes exactly 2 cycles, with one stall cycle. All other ops take 1 cycle.
- Reset asserted in RMW_WR aborts the write: mem_wr drops immediately and memory is unchanged.
- A load immediately following a RMW store sees the written data, because the write commits at the RMW_WR edge and the read is combinational next cycle.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: behaviour as above; misalign asserted and the access suppressed.
- Undefined:
  - misalign is tied to 0.
  - Misaligned accesses proceed with the low address bits truncated: halfword uses addr[1] only; word ignores addr[1:0].
  - range_err is still checked.

Test Plan:
- Reset=0 for 2 cycles, then release -> all outputs 0, state IDLE.
- SW addr=0x8, wdata=0xDEADBEEF, then LW addr=0x8 -> mem_wr=1 with mem_addr=0x8 in one cycle, stall=0; LW rdata=0xDEADBEEF.
- Word 0x8 = 0xDEADBEEF; SB addr=0x9, wdata=0x55 -> cycle1 stall=1, mem_rd=1; cycle2 mem_wr=1 with mem_wdata=0xDEAD55EF; next LBU 0x9 -> 0x00000055.
- Word 0x4 = 0x8001F00F; LH 0x6 -> 0xFFFF8001; LHU 0x6 -> 0x00008001; LB 0x4 -> 0x0000000F; LB 0x5 -> 0xFFFFFFF0.
- With MISALIGN_TRAP_EN, LW 0x2 -> misalign=1, mem_rd=0, rdata=0. Without it, LW 0x2 reads word 0x0.
- SH 0x40 with RAM_SIZE=16 -> range_err=1, no access. SH 0x4 with reset pulsed low during RMW_WR -> mem_wr deasserts and word 0x4 is unchanged.
